// File: rtl/cache_tag_lookup.sv
// cache_tag_lookup: lookup/fill controller sitting in front of the tag memory.
//
// Takes one request at a time (set index, tag, security domain), compares the tag
// against the ways the domain may use (DAWG way partitioning) and reports hit/miss.
// On a miss a victim is picked inside the domain's partition, a refill is requested,
// and once fill_valid arrives the new tag entry is written back to the tag memory.
//
// Tag entry layout (ENTRY_W = TAG_BITS + 2): [ENTRY_W-1] valid, [ENTRY_W-2] dirty,
// [TAG_BITS-1:0] tag.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_index/tag/dom        request set index, lookup tag, security domain
//   dom_way_mask             per-domain way permissions, domain d owns [d*WAY_NUM +: WAY_NUM]
//   tag_index                set address to the tag memory
//   tag_read                 per-way entries read combinationally at tag_index
//   tag_req_we/way_index/tag_write   tag memory write port (used only in fill)
//   miss_valid/way/wb/wb_tag refill request and victim writeback info
//   fill_valid               refill done
//   resp_valid/hit/way/err   one-cycle response
//
// Optional: define CACHE_TAG_LOOKUP_STATS_EN to add saturating stat_hits/stat_misses.
module cache_tag_lookup #(
    parameter int unsigned WAY_NUM    = 4,
    parameter int unsigned SET_BITS   = 10,
    parameter int unsigned TAG_BITS   = 20,
    parameter int unsigned DOMAIN_NUM = 2,
    parameter int unsigned DOM_BITS   = 1,
    localparam int unsigned WAY_W     = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
    localparam int unsigned ENTRY_W   = TAG_BITS + 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [SET_BITS-1:0]                 req_index,
    input  logic [TAG_BITS-1:0]                 req_tag,
    input  logic [DOM_BITS-1:0]                 req_dom,
    input  logic [DOMAIN_NUM*WAY_NUM-1:0]       dom_way_mask,
    output logic [SET_BITS-1:0]                 tag_index,
    output logic [WAY_W-1:0]                    way_index,
    input  logic [WAY_NUM-1:0][ENTRY_W-1:0]     tag_read,
    output logic                                tag_req_we,
    output logic [ENTRY_W-1:0]                  tag_write,
    output logic                                miss_valid,
    output logic [WAY_W-1:0]                    miss_way,
    output logic                                miss_wb,
    output logic [TAG_BITS-1:0]                 miss_wb_tag,
    input  logic                                fill_valid,
    output logic                                resp_valid,
    output logic                                resp_hit,
    output logic [WAY_W-1:0]                    resp_way,
    output logic                                resp_err
`ifdef CACHE_TAG_LOOKUP_STATS_EN
    ,
    output logic [31:0]                         stat_hits,
    output logic [31:0]                         stat_misses
`endif
);

    typedef enum logic [2:0] {StIdle, StLookup, StMiss, StFill, StResp} state_e;

    state_e                  state_q, state_d;
    logic [SET_BITS-1:0]     index_q, index_d;
    logic [TAG_BITS-1:0]     tag_q, tag_d;
    logic [DOM_BITS-1:0]     dom_q, dom_d;
    logic [WAY_W-1:0]        victim_q, victim_d;
    logic                    wb_q, wb_d;
    logic [TAG_BITS-1:0]     wb_tag_q, wb_tag_d;
    logic                    hit_q, hit_d;
    logic                    err_q, err_d;
    logic [WAY_W-1:0]        resp_way_q, resp_way_d;
    logic [DOMAIN_NUM-1:0][WAY_W-1:0] ptr_q, ptr_d;
`ifdef CACHE_TAG_LOOKUP_STATS_EN
    logic [31:0]             hits_q, hits_d;
    logic [31:0]             misses_q, misses_d;
`endif

    logic [WAY_NUM-1:0]      mask;
    logic [WAY_W-1:0]        ptr_cur;
    logic [WAY_NUM-1:0]      hit_vec;
    logic                    hit_any, inv_any;
    logic [WAY_W-1:0]        hit_way, inv_way, rr_way, victim_sel;
    logic [ENTRY_W-1:0]      victim_entry;

    // First way at or after 'start' (wrapping) whose mask bit is set.
    function automatic logic [WAY_W-1:0] next_permitted(input logic [WAY_NUM-1:0] m,
                                                        input int unsigned start);
        logic        found;
        int unsigned w;
        next_permitted = '0;
        found          = 1'b0;
        for (int unsigned k = 0; k < WAY_NUM; k++) begin
            w = (start + k) % WAY_NUM;
            if (!found && m[w]) begin
                next_permitted = WAY_W'(w);
                found          = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        tag_d      = tag_q;
        dom_d      = dom_q;
        victim_d   = victim_q;
        wb_d       = wb_q;
        wb_tag_d   = wb_tag_q;
        hit_d      = hit_q;
        err_d      = err_q;
        resp_way_d = resp_way_q;
        ptr_d      = ptr_q;
`ifdef CACHE_TAG_LOOKUP_STATS_EN
        hits_d     = hits_q;
        misses_d   = misses_q;
`endif

        // Domain ids beyond DOMAIN_NUM see an empty mask and get an error response.
        mask    = '0;
        ptr_cur = '0;
        for (int unsigned d = 0; d < DOMAIN_NUM; d++) begin
            if (dom_q == DOM_BITS'(d)) begin
                mask    = dom_way_mask[d*WAY_NUM +: WAY_NUM];
                ptr_cur = ptr_q[d];
            end
        end

        hit_any = 1'b0;
        inv_any = 1'b0;
        hit_way = '0;
        inv_way = '0;
        for (int unsigned w = 0; w < WAY_NUM; w++) begin
            hit_vec[w] = mask[w] & tag_read[w][ENTRY_W-1] & (tag_read[w][TAG_BITS-1:0] == tag_q);
            if (!hit_any && hit_vec[w]) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_any && mask[w] && !tag_read[w][ENTRY_W-1]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        rr_way       = next_permitted(mask, 32'(ptr_cur));
        victim_sel   = inv_any ? inv_way : rr_way;
        victim_entry = tag_read[victim_sel];

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    index_d = req_index;
                    tag_d   = req_tag;
                    dom_d   = req_dom;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                hit_d      = 1'b0;
                err_d      = 1'b0;
                resp_way_d = '0;
                if (mask == '0) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (hit_any) begin
                    hit_d      = 1'b1;
                    resp_way_d = hit_way;
                    state_d    = StResp;
`ifdef CACHE_TAG_LOOKUP_STATS_EN
                    if (hits_q != '1) hits_d = hits_q + 32'd1;
`endif
                end else begin
                    victim_d = victim_sel;
                    wb_d     = victim_entry[ENTRY_W-1] & victim_entry[ENTRY_W-2];
                    wb_tag_d = victim_entry[TAG_BITS-1:0];
                    state_d  = StMiss;
                end
            end
            StMiss: begin
                if (fill_valid) state_d = StFill;
            end
            StFill: begin
                for (int unsigned d = 0; d < DOMAIN_NUM; d++) begin
                    if (dom_q == DOM_BITS'(d)) ptr_d[d] = next_permitted(mask, 32'(victim_q) + 1);
                end
                hit_d      = 1'b0;
                err_d      = 1'b0;
                resp_way_d = victim_q;
                state_d    = StResp;
`ifdef CACHE_TAG_LOOKUP_STATS_EN
                if (misses_q != '1) misses_d = misses_q + 32'd1;
`endif
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            index_q    <= '0;
            tag_q      <= '0;
            dom_q      <= '0;
            victim_q   <= '0;
            wb_q       <= 1'b0;
            wb_tag_q   <= '0;
            hit_q      <= 1'b0;
            err_q      <= 1'b0;
            resp_way_q <= '0;
            ptr_q      <= '0;
`ifdef CACHE_TAG_LOOKUP_STATS_EN
            hits_q     <= '0;
            misses_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            tag_q      <= tag_d;
            dom_q      <= dom_d;
            victim_q   <= victim_d;
            wb_q       <= wb_d;
            wb_tag_q   <= wb_tag_d;
            hit_q      <= hit_d;
            err_q      <= err_d;
            resp_way_q <= resp_way_d;
            ptr_q      <= ptr_d;
`ifdef CACHE_TAG_LOOKUP_STATS_EN
            hits_q     <= hits_d;
            misses_q   <= misses_d;
`endif
        end
    end

    // Outputs are gated by state so they read as zero outside the phase that owns them.
    assign req_ready   = (state_q == StIdle);
    assign tag_index   = index_q;
    assign tag_req_we  = (state_q == StFill);
    assign way_index   = (state_q == StFill) ? victim_q : '0;
    assign tag_write   = (state_q == StFill) ? {1'b1, 1'b0, tag_q} : '0;
    assign miss_valid  = (state_q == StMiss);
    assign miss_way    = (state_q == StMiss) ? victim_q : '0;
    assign miss_wb     = (state_q == StMiss) & wb_q;
    assign miss_wb_tag = (state_q == StMiss) ? wb_tag_q : '0;
    assign resp_valid  = (state_q == StResp);
    assign resp_hit    = (state_q == StResp) & hit_q;
    assign resp_way    = (state_q == StResp) ? resp_way_q : '0;
    assign resp_err    = (state_q == StResp) & err_q;
`ifdef CACHE_TAG_LOOKUP_STATS_EN
    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule
